// File: rtl/breath_ramp.sv
// Breathing-waveform duty generator: rise / hold-high / fall / hold-low, stepped by a
// tick prescaler, with the duty output double-buffered onto PWM period boundaries.
module breath_ramp #(
   parameter int BITS     = 10,
   parameter int RANGE    = 999,
   parameter int TICK_DIV = 12000,
   parameter int HOLD_TOP = 200,
   parameter int HOLD_BOT = 200
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            enable,
   input  logic [BITS-1:0] step,
   input  logic            period_end,
   output logic [BITS-1:0] value,
   output logic            value_valid,
   output logic [1:0]      phase,
   output logic            cycle_done
);

   localparam int PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int HMAX  = (HOLD_TOP > HOLD_BOT) ? HOLD_TOP : HOLD_BOT;
   localparam int HW    = (HMAX > 2) ? $clog2(HMAX) : 1;
   localparam logic [PW-1:0]   P_LAST  = PW'(TICK_DIV - 1);
   localparam logic [HW-1:0]   HT_LAST = HW'((HOLD_TOP > 0) ? HOLD_TOP - 1 : 0);
   localparam logic [HW-1:0]   HB_LAST = HW'((HOLD_BOT > 0) ? HOLD_BOT - 1 : 0);
   localparam logic [BITS-1:0] RANGE_L = BITS'(RANGE);

   typedef enum logic [1:0] {
      RISE    = 2'd0,
      HOLD_HI = 2'd1,
      FALL    = 2'd2,
      HOLD_LO = 2'd3
   } state_t;

   state_t          r_state;
   logic [PW-1:0]   r_presc;
   logic [HW-1:0]   r_hold;
   logic [BITS-1:0] r_level;
   logic [BITS-1:0] r_value;
   logic            r_valid;
   logic            r_done;

   logic            w_tick;
   logic [BITS-1:0] w_s;
   logic [BITS-1:0] w_up;
   logic [BITS-1:0] w_dn;

   // Level arithmetic runs one bit wider than the level so the sum never wraps.
   function automatic logic [BITS-1:0] sat_up(input logic [BITS-1:0] lvl,
                                              input logic [BITS-1:0] s);
      logic [BITS:0] sum;
      sum = {1'b0, lvl} + {1'b0, s};
      sat_up = (sum >= (BITS+1)'(RANGE)) ? RANGE_L : sum[BITS-1:0];
   endfunction

   function automatic logic [BITS-1:0] sat_dn(input logic [BITS-1:0] lvl,
                                              input logic [BITS-1:0] s);
      sat_dn = (lvl <= s) ? '0 : (lvl - s);
   endfunction

   assign w_tick = enable && (r_presc == P_LAST);
   assign w_s    = (step == '0) ? BITS'(1) : step;
   assign w_up   = sat_up(r_level, w_s);
   assign w_dn   = sat_dn(r_level, w_s);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= RISE;
         r_presc <= '0;
         r_hold  <= '0;
         r_level <= '0;
         r_value <= '0;
         r_valid <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         // The buffer captures the pre-edge level, so a coincident tick lands next period.
         r_valid <= period_end;
         r_done  <= 1'b0;
         if (period_end)
            r_value <= r_level;
         if (enable)
            r_presc <= w_tick ? '0 : r_presc + PW'(1);
         if (w_tick) begin
            case (r_state)
               RISE: begin
                  r_level <= w_up;
                  if (w_up == RANGE_L) begin
                     r_hold  <= '0;
                     r_state <= (HOLD_TOP == 0) ? FALL : HOLD_HI;
                  end
               end
               HOLD_HI: begin
                  if (r_hold == HT_LAST) begin
                     r_hold  <= '0;
                     r_state <= FALL;
                  end else begin
                     r_hold <= r_hold + HW'(1);
                  end
               end
               FALL: begin
                  r_level <= w_dn;
                  if (w_dn == '0) begin
                     r_done  <= 1'b1;
                     r_hold  <= '0;
                     r_state <= (HOLD_BOT == 0) ? RISE : HOLD_LO;
                  end
               end
               default: begin
                  if (r_hold == HB_LAST) begin
                     r_hold  <= '0;
                     r_state <= RISE;
                  end else begin
                     r_hold <= r_hold + HW'(1);
                  end
               end
            endcase
         end
      end
   end

   assign value       = r_value;
   assign value_valid = r_valid;
   assign phase       = r_state;
   assign cycle_done  = r_done;

endmodule

// File: tb/tb_breath_ramp.sv
// Bench for breath_ramp: two instances (with and without a top hold) driven by
// directed and random stimulus, compared each cycle against a behavioural model.
module tb_breath_ramp;

   localparam int BITS = 4;
   localparam int RNG  = 9;
   localparam int TDIV = 4;
   localparam int HB   = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       enable = 1'b0;
   logic [3:0] step = 4'd1;
   logic       period_end = 1'b1;

   logic [3:0] val_a, val_b;
   logic       vv_a, vv_b, cd_a, cd_b;
   logic [1:0] ph_a, ph_b;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   breath_ramp #(.BITS(BITS), .RANGE(RNG), .TICK_DIV(TDIV), .HOLD_TOP(2), .HOLD_BOT(HB)) u_a (
      .clk(clk), .rst(rst), .enable(enable), .step(step), .period_end(period_end),
      .value(val_a), .value_valid(vv_a), .phase(ph_a), .cycle_done(cd_a));

   breath_ramp #(.BITS(BITS), .RANGE(RNG), .TICK_DIV(TDIV), .HOLD_TOP(0), .HOLD_BOT(HB)) u_b (
      .clk(clk), .rst(rst), .enable(enable), .step(step), .period_end(period_end),
      .value(val_b), .value_valid(vv_b), .phase(ph_b), .cycle_done(cd_b));

   typedef struct {
      int cnt; int lvl; int ph; int hc; int val; int vv; int cd;
   } mdl_t;

   mdl_t ma, mb;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Phase numbering: 0 rising, 1 held at full, 2 falling, 3 held dark.
   function automatic mdl_t mstep(mdl_t m, int htop, bit r, bit en, int st, bit pe);
      mdl_t n;
      int   s;
      n = m;
      n.vv = 0;
      n.cd = 0;
      if (r) begin
         n.cnt = 0; n.lvl = 0; n.ph = 0; n.hc = 0; n.val = 0;
         return n;
      end
      if (pe) begin
         n.val = m.lvl;
         n.vv  = 1;
      end
      if (en) n.cnt = (m.cnt + 1) % TDIV;
      if (en && m.cnt == TDIV - 1) begin
         s = (st == 0) ? 1 : st;
         if (m.ph == 0) begin
            n.lvl = (m.lvl + s > RNG) ? RNG : m.lvl + s;
            if (n.lvl == RNG) begin n.ph = (htop == 0) ? 2 : 1; n.hc = 0; end
         end else if (m.ph == 2) begin
            n.lvl = (m.lvl - s < 0) ? 0 : m.lvl - s;
            if (n.lvl == 0) begin n.ph = (HB == 0) ? 0 : 3; n.hc = 0; n.cd = 1; end
         end else begin
            if (m.hc + 1 >= ((m.ph == 1) ? htop : HB)) begin
               n.ph = (m.ph == 1) ? 2 : 0; n.hc = 0;
            end else begin
               n.hc = m.hc + 1;
            end
         end
      end
      return n;
   endfunction

   task automatic cyc(input bit r, input bit en, input int st, input bit pe);
      rst = r; enable = en; step = st[3:0]; period_end = pe;
      @(posedge clk);
      ma = mstep(ma, 2, r, en, st, pe);
      mb = mstep(mb, 0, r, en, st, pe);
      #1;
      check("a.value", int'(val_a), ma.val);
      check("a.valid", int'(vv_a), ma.vv);
      check("a.phase", int'(ph_a), ma.ph);
      check("a.done",  int'(cd_a), ma.cd);
      check("b.value", int'(val_b), mb.val);
      check("b.valid", int'(vv_b), mb.vv);
      check("b.phase", int'(ph_b), mb.ph);
      check("b.done",  int'(cd_b), mb.cd);
   endtask

   initial begin
      int done_cnt;
      int guard;
      ma = '{0, 0, 0, 0, 0, 0, 0};
      mb = '{0, 0, 0, 0, 0, 0, 0};

      // Reset held three cycles, then the first tick lands on the 4th enabled cycle.
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1, 1'b1);
      check("rst.value", int'(val_a), 0);
      check("rst.phase", int'(ph_a), 0);
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1, 1'b1);
      check("tick4.value_old", int'(val_a), 0);
      cyc(1'b0, 1'b1, 1, 1'b1);
      check("tick4.value_new", int'(val_a), 1);

      // Two full 88-cycle periods at step 1: exactly one cycle_done per period.
      done_cnt = 0;
      for (int i = 0; i < 176; i++) begin
         cyc(1'b0, 1'b1, 1, 1'b1);
         done_cnt += int'(cd_a);
      end
      check("period.done_count", done_cnt, 2);

      // Saturating steps, then step 0 acting as 1.
      for (int i = 0; i < 120; i++) cyc(1'b0, 1'b1, 4, 1'b1);
      for (int i = 0; i < 100; i++) cyc(1'b0, 1'b1, 0, 1'b1);

      // Sparse period boundaries.
      for (int i = 0; i < 150; i++) cyc(1'b0, 1'b1, 1 + (i / 50), (i % 5) == 4);

      // Pause mid-rise at level 5.
      cyc(1'b1, 1'b1, 1, 1'b1);
      guard = 0;
      while (!(ma.ph == 0 && ma.lvl == 5 && ma.cnt == 1) && guard < 400) begin
         cyc(1'b0, 1'b1, 1, 1'b1);
         guard++;
      end
      check("pause.reach", int'(guard < 400), 1);
      for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1, 1'b1);
      check("pause.frozen", int'(val_a), 5);
      for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 1, 1'b1);

      // Reset during FALL at level 6.
      guard = 0;
      while (!(ma.ph == 2 && ma.lvl == 6) && guard < 400) begin
         cyc(1'b0, 1'b1, 1, 1'b1);
         guard++;
      end
      check("midrst.reach", int'(guard < 400), 1);
      cyc(1'b1, 1'b1, 1, 1'b1);
      check("midrst.value", int'(val_a), 0);
      check("midrst.phase", int'(ph_a), 0);
      check("midrst.done",  int'(cd_a), 0);
      for (int i = 0; i < 60; i++) cyc(1'b0, 1'b1, 1, 1'b1);

      // Randomised operation with occasional resets.
      for (int i = 0; i < 3000; i++)
         cyc($urandom_range(0, 99) == 0, $urandom_range(0, 7) != 0,
             int'($urandom_range(0, 15)), $urandom_range(0, 2) != 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
